mfi_pc_chain_check: RTL and testbench
=====================================

# mfi_pc_chain_check

Parametrised multi-retire successor to the single-channel PC-forward checker in the `checks/` suite. It watches NRET formal-interface retire channels, captures the `pc_wdata` of the instruction whose order is `inst_order-1`, and checks that the `pc_rdata` of instruction `inst_order` matches it. It also checks IALIGN alignment and in-cycle channel ordering, and enforces a retire-gap timeout. Results appear both as formal `assert`s and as sticky error outputs for simulation benches.

## Interface
- `XLEN`, 32: PC width, 32 or 64.
- `NRET`, 1: retire channels per cycle, 1..8.
- `IALIGN`, 32: required PC alignment in bits, 16 or 32.
- `MAX_GAP`, 64: maximum cycles allowed between the predecessor and the target retiring; 0 disables the timeout.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `check`  in  1  comparison enable. Tracking runs regardless; errors are raised only while this is high.
- `inst_order`  in  64  target order. Must stay stable after reset; formal wrappers drive a const-rand reg.
- `mfi_valid`  in  NRET  per-channel retire valid.
- `mfi_order`  in  64*NRET  per-channel order, channel i at `[64*i +: 64]`.
- `mfi_halt`  in  NRET  instruction halts the hart; no successor follows.
- `mfi_pc_rdata`, `mfi_pc_wdata`  in  XLEN*NRET  each; per-channel PCs.
- `state`  out  2  FSM state.
- `done`  out  1  the target was checked, or waived.
- `err_mismatch`, `err_align`, `err_order`, `err_timeout`  out  1  each; sticky error flags.

## Operation
- FSM states:
  - IDLE: waiting for the predecessor.
  - ARMED: `expect_pc` is captured and the block is waiting for the target.
  - DONE: terminal until reset.
  - FAIL: terminal until reset.
- Predecessor hit: some valid channel i has `order == inst_order-1`. Capture `expect_pc = pc_wdata[i]` and go IDLE→ARMED.
  - If `halt[i]` is set, go to DONE with `done=1` and no compare.
- Target hit: some valid channel j has `order == inst_order`.
  - In ARMED: compare `pc_rdata[j]` against `expect_pc`.
  - Same cycle as the predecessor with i<j: compare against `pc_wdata[i]` directly (bypass).
  - In IDLE with no same-cycle predecessor (target order 0, or the predecessor predates tracking): go to DONE with no compare.
  - On a match, or with `check` low: go to DONE.
  - On a mismatch with `check` high: set `err_mismatch` and go to FAIL.
- Alignment: on a target hit with `check` high, `pc_rdata[j]` must have zero bits below `IALIGN/8`. A violation sets `err_align`. This check is independent of the FSM outcome.
- Ordering, every cycle, with `check` high:
  - Valid bits must be contiguous from channel 0.
  - Orders on valid channels must strictly increase by 1 with channel index.
  - A violation sets `err_order`. This is what covers a target appearing on a lower channel than its predecessor.
- Timeout: a gap counter resets on entry to ARMED and saturates at `MAX_GAP`. Reaching `MAX_GAP` in ARMED with `check` high sets `err_timeout` and moves to FAIL.
- Duplicate predecessor hits in ARMED re-capture `expect_pc` (last wins). Order wrap at 2^64 is ignored; `inst_order-1` is modular.
- Formal build: each `err_*` set condition is also an immediate `assert`. With `check` high, a target hit is `assume`d to be present.

## Timing
- Reset (async): `state`=IDLE, `expect_pc`=0, gap counter 0, `done`=0, all `err_*`=0.
- Capture and compare happen on the same clock edge. All outputs are registered: a violation sampled at edge N shows on outputs after edge N. Errors are sticky until reset.
- Latency from target retire to `done` or `err_*` is exactly 1 cycle.
- Reset asserted mid-ARMED aborts tracking immediately. A target arriving after reset release is then treated as a no-predecessor case (DONE, no compare).
- The gap counter increments on every ARMED cycle without a target hit. The timeout fires on the cycle the count equals `MAX_GAP`.

## Structure
- Package `mfi_check_pkg`:
  - `ORDER_W`=64.
  - `chk_state_e` {IDLE, ARMED, DONE, FAIL}.
  - An alignment-mask function of XLEN and IALIGN.
- Sub-module `mfi_order_match`: per-channel comparators plus a priority encoder.
  - Outputs: `pred_hit`, `pred_idx`, `tgt_hit`, `tgt_idx`, `order_ok`.
  - Instantiated once; parametrised by NRET.

## Test plan
- NRET=1, inst_order=5: order 4 with wdata 0x100, then order 5 with rdata 0x100 → `done`=1, no errors, state DONE 1 cycle later.
- NRET=2, same cycle: ch0 order 9 wdata 0x2000, ch1 order 10 rdata 0x2004 → `err_mismatch`=1, FAIL.
- NRET=2, swapped channels: ch0 order 10, ch1 order 9 → `err_order`=1.
- IALIGN=32: target rdata 0x102 with correct forwarding → `err_align`=1 and `done`=1.
- MAX_GAP=4: predecessor retires, then 4 idle cycles → `err_timeout`=1 on the 4th; with `check`=0 no error is raised.
- Reset pulsed while ARMED, then target retires → state DONE, no `err_*`, `expect_pc` reads 0 after reset.

Source files
------------

// File: rtl/mfi_pc_chain_check_pkg.sv
// Shared types and helpers for the multi-retire PC chain checker.
package mfi_check_pkg;

  localparam int unsigned ORDER_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2,
    FAIL  = 2'd3
  } chk_state_e;

  // Bits of a PC that must be zero for an IALIGN-aligned address.
  function automatic logic [63:0] align_mask(input int unsigned xlen, input int unsigned ialign);
    logic [63:0] m;
    m = 64'(ialign / 8) - 64'd1;
    if (xlen < 64) m = m & ((64'd1 << xlen) - 64'd1);
    return m;
  endfunction

endpackage

// File: rtl/mfi_pc_chain_check_if.sv
// Retire-channel bundle and checker result signals.
interface mfi_pc_chain_check_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRET = 1
);
  logic                                   check;
  logic [mfi_check_pkg::ORDER_W-1:0]      inst_order;
  logic [NRET-1:0]                        mfi_valid;
  logic [mfi_check_pkg::ORDER_W*NRET-1:0] mfi_order;
  logic [NRET-1:0]                        mfi_halt;
  logic [XLEN*NRET-1:0]                   mfi_pc_rdata;
  logic [XLEN*NRET-1:0]                   mfi_pc_wdata;
  logic [1:0]                             state;
  logic                                   done;
  logic                                   err_mismatch;
  logic                                   err_align;
  logic                                   err_order;
  logic                                   err_timeout;

  modport master (
    output check, inst_order, mfi_valid, mfi_order, mfi_halt, mfi_pc_rdata, mfi_pc_wdata,
    input  state, done, err_mismatch, err_align, err_order, err_timeout
  );

  modport slave (
    input  check, inst_order, mfi_valid, mfi_order, mfi_halt, mfi_pc_rdata, mfi_pc_wdata,
    output state, done, err_mismatch, err_align, err_order, err_timeout
  );
endinterface

// File: rtl/mfi_pc_chain_check_order_match.sv
// Per-channel order comparators, lowest-channel priority encoders and in-cycle ordering check.
module mfi_order_match
  import mfi_check_pkg::*;
#(
  parameter int unsigned NRET  = 1,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NRET-1:0]         mfi_valid,
  input  logic [ORDER_W*NRET-1:0] mfi_order,
  input  logic [ORDER_W-1:0]      inst_order,
  output logic                    pred_hit,
  output logic [IDX_W-1:0]        pred_idx,
  output logic                    tgt_hit,
  output logic [IDX_W-1:0]        tgt_idx,
  output logic                    order_ok
);

  logic [ORDER_W-1:0] pred_order;
  logic [ORDER_W-1:0] ch_ord;
  logic [ORDER_W-1:0] prev_ord;

  assign pred_order = inst_order - 64'd1;

  // Scan high to low so the lowest matching channel wins.
  always_comb begin
    pred_hit = 1'b0;
    pred_idx = '0;
    tgt_hit  = 1'b0;
    tgt_idx  = '0;
    ch_ord   = '0;
    for (int unsigned i = NRET; i > 0; i--) begin
      ch_ord = mfi_order[(i-1)*ORDER_W +: ORDER_W];
      if (mfi_valid[i-1] && ch_ord == pred_order) begin
        pred_hit = 1'b1;
        pred_idx = IDX_W'(i-1);
      end
      if (mfi_valid[i-1] && ch_ord == inst_order) begin
        tgt_hit = 1'b1;
        tgt_idx = IDX_W'(i-1);
      end
    end
  end

  always_comb begin
    order_ok = 1'b1;
    prev_ord = '0;
    for (int unsigned i = 1; i < NRET; i++) begin
      prev_ord = mfi_order[(i-1)*ORDER_W +: ORDER_W];
      if (mfi_valid[i] && !mfi_valid[i-1]) order_ok = 1'b0;
      if (mfi_valid[i] && mfi_valid[i-1] &&
          mfi_order[i*ORDER_W +: ORDER_W] != prev_ord + 64'd1) order_ok = 1'b0;
    end
  end

endmodule

// File: rtl/mfi_pc_chain_check.sv
// Checks that pc_rdata of retire inst_order equals pc_wdata of inst_order-1 across NRET channels.
module mfi_pc_chain_check
  import mfi_check_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NRET    = 1,
  parameter int unsigned IALIGN  = 32,
  parameter int unsigned MAX_GAP = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  mfi_pc_chain_check_if.slave  bus
);

  localparam int unsigned     IDX_W   = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int unsigned     GAP_W   = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
  localparam logic [XLEN-1:0] ALIGN_M = XLEN'(align_mask(XLEN, IALIGN));
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MAX_GAP);

  chk_state_e       state_q;
  logic [XLEN-1:0]  expect_pc_q;
  logic [GAP_W-1:0] gap_q;
  logic             done_q;
  logic             err_mismatch_q;
  logic             err_align_q;
  logic             err_order_q;
  logic             err_timeout_q;

  logic             pred_hit;
  logic             tgt_hit;
  logic             order_ok;
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] tgt_idx;
  logic [XLEN-1:0]  pred_pc;
  logic [XLEN-1:0]  tgt_rdata;
  logic [XLEN-1:0]  cmp_ref;
  logic             pred_halt;
  logic             bypass;
  logic             cmp_ok;
  logic             align_bad;
  logic [GAP_W-1:0] gap_inc;

  mfi_order_match #(.NRET(NRET), .IDX_W(IDX_W)) u_match (
    .mfi_valid  (bus.mfi_valid),
    .mfi_order  (bus.mfi_order),
    .inst_order (bus.inst_order),
    .pred_hit   (pred_hit),
    .pred_idx   (pred_idx),
    .tgt_hit    (tgt_hit),
    .tgt_idx    (tgt_idx),
    .order_ok   (order_ok)
  );

  assign pred_pc   = bus.mfi_pc_wdata[pred_idx*XLEN +: XLEN];
  assign tgt_rdata = bus.mfi_pc_rdata[tgt_idx*XLEN +: XLEN];
  assign pred_halt = bus.mfi_halt[pred_idx];
  assign bypass    = pred_hit && tgt_hit && (pred_idx < tgt_idx);
  // A same-cycle predecessor on a lower channel is fresher than the captured PC.
  assign cmp_ref   = bypass ? pred_pc : expect_pc_q;
  assign cmp_ok    = !bus.check || (tgt_rdata == cmp_ref);
  assign align_bad = |(tgt_rdata & ALIGN_M);
  assign gap_inc   = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      expect_pc_q    <= '0;
      gap_q          <= '0;
      done_q         <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_align_q    <= 1'b0;
      err_order_q    <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      if (bus.check && !order_ok) err_order_q <= 1'b1;
      if (bus.check && tgt_hit && align_bad) err_align_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (pred_hit && pred_halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (tgt_hit) begin
            if (!bypass || cmp_ok) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q        <= FAIL;
              err_mismatch_q <= 1'b1;
            end
          end else if (pred_hit) begin
            state_q     <= ARMED;
            expect_pc_q <= pred_pc;
            gap_q       <= '0;
          end
        end
        ARMED: begin
          if (tgt_hit) begin
            if (cmp_ok) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q        <= FAIL;
              err_mismatch_q <= 1'b1;
            end
          end else if (pred_hit && pred_halt) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            if (pred_hit) expect_pc_q <= pred_pc;
            gap_q <= gap_inc;
            if (MAX_GAP != 0 && bus.check && gap_inc == GAP_MAX) begin
              state_q       <= FAIL;
              err_timeout_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FORMAL
  always_comb begin
    if (!reset && bus.check) begin
      assume (tgt_hit);
      assert (order_ok);
      assert (!(tgt_hit && align_bad));
      assert (!(tgt_hit && (state_q == ARMED || bypass) && !cmp_ok));
      assert (!(state_q == ARMED && !tgt_hit && !(pred_hit && pred_halt) &&
                MAX_GAP != 0 && gap_inc == GAP_MAX));
    end
  end
`endif

  assign bus.state        = state_q;
  assign bus.done         = done_q;
  assign bus.err_mismatch = err_mismatch_q;
  assign bus.err_align    = err_align_q;
  assign bus.err_order    = err_order_q;
  assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_mfi_pc_chain_check.sv
// Directed bench for mfi_pc_chain_check with NRET=2, IALIGN=32, MAX_GAP=4.
module tb_mfi_pc_chain_check;
  import mfi_check_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NRET    = 2;
  localparam int unsigned IALIGN  = 32;
  localparam int unsigned MAX_GAP = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  always #5 clock = ~clock;

  mfi_pc_chain_check_if #(.XLEN(XLEN), .NRET(NRET)) bus ();

  mfi_pc_chain_check #(
    .XLEN(XLEN), .NRET(NRET), .IALIGN(IALIGN), .MAX_GAP(MAX_GAP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.mfi_valid    = '0;
    bus.mfi_halt     = '0;
    bus.mfi_order    = '0;
    bus.mfi_pc_rdata = '0;
    bus.mfi_pc_wdata = '0;
  endtask

  task automatic set_ch(input int ch, input logic [63:0] ord, input logic [31:0] rd,
                        input logic [31:0] wd, input logic halt);
    bus.mfi_valid[ch]          = 1'b1;
    bus.mfi_halt[ch]           = halt;
    bus.mfi_order[ch*64 +: 64] = ord;
    bus.mfi_pc_rdata[ch*32 +: 32] = rd;
    bus.mfi_pc_wdata[ch*32 +: 32] = wd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [63:0] order);
    idle();
    bus.inst_order = order;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [3:0] errs();
    return {bus.err_mismatch, bus.err_align, bus.err_order, bus.err_timeout};
  endfunction

  initial begin
    bus.check = 1'b1;
    reset     = 1'b0;
    idle();
    bus.inst_order = 64'd5;

    // Reset values
    reset = 1'b1;
    step();
    chk("rst_state", 64'(bus.state), 64'(IDLE));
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_errs", 64'(errs()), 64'd0);
    chk("rst_expect", 64'(dut.expect_pc_q), 64'd0);
    reset = 1'b0;

    // Single channel forward: order 4 then order 5
    do_reset(64'd5);
    set_ch(0, 64'd4, 32'h0, 32'h100, 1'b0);
    step();
    chk("fwd_armed", 64'(bus.state), 64'(ARMED));
    chk("fwd_expect", 64'(dut.expect_pc_q), 64'h100);
    chk("fwd_notdone", 64'(bus.done), 64'd0);
    idle();
    set_ch(0, 64'd5, 32'h100, 32'h104, 1'b0);
    step();
    chk("fwd_done", 64'(bus.done), 64'd1);
    chk("fwd_state", 64'(bus.state), 64'(DONE));
    chk("fwd_errs", 64'(errs()), 64'd0);

    // Same-cycle bypass with wrong rdata
    do_reset(64'd10);
    set_ch(0, 64'd9, 32'h1ffc, 32'h2000, 1'b0);
    set_ch(1, 64'd10, 32'h2004, 32'h2008, 1'b0);
    step();
    chk("byp_errs", 64'(errs()), 64'b1000);
    chk("byp_state", 64'(bus.state), 64'(FAIL));
    chk("byp_done", 64'(bus.done), 64'd0);

    // Same-cycle bypass, correct
    do_reset(64'd10);
    set_ch(0, 64'd9, 32'h1ffc, 32'h2000, 1'b0);
    set_ch(1, 64'd10, 32'h2000, 32'h2004, 1'b0);
    step();
    chk("bypok_done", 64'(bus.done), 64'd1);
    chk("bypok_errs", 64'(errs()), 64'd0);

    // Swapped channels
    do_reset(64'd10);
    set_ch(0, 64'd10, 32'h3000, 32'h3004, 1'b0);
    set_ch(1, 64'd9, 32'h2ffc, 32'h3000, 1'b0);
    step();
    chk("swap_order", 64'(bus.err_order), 64'd1);
    chk("swap_mism", 64'(bus.err_mismatch), 64'd0);

    // Non-contiguous valid bits
    do_reset(64'd50);
    set_ch(1, 64'd7, 32'h0, 32'h0, 1'b0);
    step();
    chk("gap_valid_order", 64'(bus.err_order), 64'd1);

    // Misaligned but correctly forwarded target
    do_reset(64'd5);
    set_ch(0, 64'd4, 32'h0, 32'h102, 1'b0);
    step();
    idle();
    set_ch(0, 64'd5, 32'h102, 32'h106, 1'b0);
    step();
    chk("align_errs", 64'(errs()), 64'b0100);
    chk("align_done", 64'(bus.done), 64'd1);

    // Predecessor halts
    do_reset(64'd5);
    set_ch(0, 64'd4, 32'h0, 32'h100, 1'b1);
    step();
    chk("halt_state", 64'(bus.state), 64'(DONE));
    chk("halt_done", 64'(bus.done), 64'd1);

    // Timeout after MAX_GAP idle cycles
    do_reset(64'd5);
    set_ch(0, 64'd4, 32'h0, 32'h100, 1'b0);
    step();
    idle();
    step();
    step();
    step();
    chk("to_3_err", 64'(bus.err_timeout), 64'd0);
    chk("to_3_state", 64'(bus.state), 64'(ARMED));
    step();
    chk("to_4_err", 64'(bus.err_timeout), 64'd1);
    chk("to_4_state", 64'(bus.state), 64'(FAIL));

    // check low: no timeout, mismatch tolerated
    bus.check = 1'b0;
    do_reset(64'd5);
    set_ch(0, 64'd4, 32'h0, 32'h100, 1'b0);
    step();
    idle();
    for (int k = 0; k < 5; k++) step();
    chk("nochk_state", 64'(bus.state), 64'(ARMED));
    chk("nochk_to", 64'(bus.err_timeout), 64'd0);
    set_ch(0, 64'd5, 32'h200, 32'h204, 1'b0);
    step();
    chk("nochk_done", 64'(bus.done), 64'd1);
    chk("nochk_errs", 64'(errs()), 64'd0);
    bus.check = 1'b1;

    // Asynchronous reset while armed
    do_reset(64'd5);
    set_ch(0, 64'd4, 32'h0, 32'h500, 1'b0);
    step();
    idle();
    chk("ar_expect_pre", 64'(dut.expect_pc_q), 64'h500);
    reset = 1'b1;
    #1;
    chk("ar_state", 64'(bus.state), 64'(IDLE));
    chk("ar_expect", 64'(dut.expect_pc_q), 64'd0);
    reset = 1'b0;
    set_ch(0, 64'd5, 32'h600, 32'h604, 1'b0);
    step();
    chk("ar_post_state", 64'(bus.state), 64'(DONE));
    chk("ar_post_done", 64'(bus.done), 64'd1);
    chk("ar_post_errs", 64'(errs()), 64'd0);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
